ram: RTL and testbench

// - Single-port synchronous-write RAM with one shared bidirectional data bus.
// - The bus direction follows `write`. When write=1 the master drives the bus
//   and the RAM stores it. When write=0 the RAM drives the word at `address`.
// - Generic storage leaf for small register files and scratch memories. It

---
 rtl/ram.sv | 43 ++++
 tb/tb_ram.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ram.sv
// Single-port RAM on a shared tri-state data bus; the bus direction follows `write`.
// Optional RAM_READ_REG_EN adds a one-cycle registered read path.
module ram #(
    parameter int ADDRESS_BITS = 1,
    parameter int DATA_BITS    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    inout  wire  [DATA_BITS-1:0]    data
);
    localparam int DEPTH = 1 << ADDRESS_BITS;

    logic [DEPTH-1:0][DATA_BITS-1:0] mem;
    logic [DATA_BITS-1:0]            rdata;

    // An X/Z on write falls through to the else arm, so no word is disturbed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mem <= '0;
        else if (write == 1'b1)
            mem[address] <= data;
    end

`ifdef RAM_READ_REG_EN
    logic [DATA_BITS-1:0] rreg;

    // Captures the word as it stood before this edge's write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rreg <= '0;
        else
            rreg <= mem[address];
    end

    assign rdata = rreg;
`else
    assign rdata = mem[address];
`endif

    assign data = write ? {DATA_BITS{1'bz}} : rdata;
endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: reset clearing, single/held writes, async mid-sequence reset.
module tb_ram;
    logic       clock = 1'b0;
    logic       reset;
    logic       write;
    logic [0:0] address;
    logic       drv;
    logic [0:0] wdata;
    wire  [0:0] data;

    int total = 0;
    int bad   = 0;

    assign data = drv ? wdata : 1'bz;

    ram #(.ADDRESS_BITS(1), .DATA_BITS(1)) dut (
        .clock   (clock),
        .reset   (reset),
        .write   (write),
        .address (address),
        .data    (data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [0:0] obs, input logic [0:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Read: combinational in the default build, one clock of latency with the read register.
    task automatic rd(input logic [0:0] a, input logic [0:0] exp, input string tag);
        drv     = 1'b0;
        write   = 1'b0;
        address = a;
`ifdef RAM_READ_REG_EN
        @(posedge clock);
`endif
        #1;
        chk(tag, data, exp);
    endtask

    // One write edge; the bus must carry only the master's value during the write.
    task automatic wr(input logic [0:0] a, input logic [0:0] d, input string tag);
        @(negedge clock);
        address = a;
        wdata   = d;
        drv     = 1'b1;
        write   = 1'b1;
        @(posedge clock);
        #1;
        chk(tag, data, d);
        @(negedge clock);
        write = 1'b0;
        drv   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        write   = 1'b0;
        drv     = 1'b0;
        wdata   = 1'b0;
        address = 1'b0;
        repeat (2) @(posedge clock);
        rd(1'b0, 1'b0, "rst_a0");
        rd(1'b1, 1'b0, "rst_a1");
        @(negedge clock);
        reset = 1'b0;

        wr(1'b0, 1'b1, "w1_bus");
        rd(1'b0, 1'b1, "w1_a0");
        rd(1'b1, 1'b0, "w1_a1");

        wr(1'b1, 1'b1, "w2_bus");
        rd(1'b0, 1'b1, "w2_a0");
        rd(1'b1, 1'b1, "w2_a1");

        wr(1'b0, 1'b0, "w3_bus");
        rd(1'b0, 1'b0, "w3_a0");
        rd(1'b1, 1'b1, "w3_a1");

        // write held across two rises with address/data changing between them
        @(negedge clock);
        address = 1'b0; wdata = 1'b1; drv = 1'b1; write = 1'b1;
        @(posedge clock); #1;
        chk("hold1_bus", data, 1'b1);
        @(negedge clock);
        address = 1'b1; wdata = 1'b0;
        @(posedge clock); #1;
        chk("hold2_bus", data, 1'b0);
        @(negedge clock);
        write = 1'b0; drv = 1'b0;
        rd(1'b0, 1'b1, "hold_a0");
        rd(1'b1, 1'b0, "hold_a1");

        // fill both words, then reset between edges
        wr(1'b1, 1'b1, "pre_bus");
        rd(1'b1, 1'b1, "pre_a1");
        @(negedge clock);
        #2;
        reset = 1'b1;
        address = 1'b0;
        #1;
        chk("mid_rst_a0", data, 1'b0);
        address = 1'b1;
        #1;
        chk("mid_rst_a1", data, 1'b0);

        // writes are ignored while reset is held
        @(negedge clock);
        address = 1'b0; wdata = 1'b1; drv = 1'b1; write = 1'b1;
        @(posedge clock);
        @(negedge clock);
        write = 1'b0; drv = 1'b0;
        reset = 1'b0;
        rd(1'b0, 1'b0, "rst_wr_ignored");
        rd(1'b1, 1'b0, "rst_a1_still0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
